// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: command codes, arbiter states, limits.
// Used by the write engine and the address generator.
package sdram_pkg;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;

  localparam logic [4:0] AREF  = 5'b00000;
  localparam logic [4:0] READ  = 5'b01000;
  localparam logic [4:0] WRITE = 5'b10000;

  localparam logic [3:0]  CMD_END = 4'd12;
  localparam logic [8:0]  COL_END = 9'd508;
  localparam logic [11:0] ROW_END = 12'd4095;

  // Column address word; ap drives A10 (auto-precharge).
  function automatic logic [11:0] col_word(
    input logic [8:0] col,
    input logic       ap
  );
    return {1'b0, ap, 1'b0, col};
  endfunction

endpackage

// File: rtl/sdram_wr_if.sv
// SDRAM command/data bus driven by a controller engine.
// master drives the bus, slave is the pad/mux side.
interface sdram_wr_if;

  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] sdram_dq;
  logic        sdram_dq_oe;

  modport master (
    output sdram_cmd,
    output sdram_addr,
    output sdram_bank,
    output sdram_dq,
    output sdram_dq_oe
  );

  modport slave (
    input sdram_cmd,
    input sdram_addr,
    input sdram_bank,
    input sdram_dq,
    input sdram_dq_oe
  );

endinterface

// File: rtl/sdram_addr_gen.sv
// Sequential row/column counter, advanced by one 4-word burst per pulse.
// Wraps through all rows and columns back to 0.
module sdram_addr_gen
  import sdram_pkg::*;
(
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        adv,
  output logic [11:0] row,
  output logic [8:0]  col
);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == COL_END) begin
        col <= '0;
        row <= (row == ROW_END) ? '0 : row + 12'd1;
      end else begin
        col <= col + 9'd4;
      end
    end
  end

endmodule

// File: rtl/sdram_wr.sv
// SDRAM write engine: PRE/ACT/WR sequences with 4-beat bursts from a FIFO.
// Define SDRAM_WR_AUTO_PRE_EN for auto-precharge writes (ACT every burst).
module sdram_wr
  import sdram_pkg::*;
(
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        wr_en,
  input  logic [4:0]  state,
  input  logic        ref_req,
  input  logic        key_wr,
  input  logic [15:0] wr_data,
  sdram_wr_if.master  bus,
  output logic        wr_req,
  output logic        flag_wr_end,
  output logic        fifo_rd_en
);

  logic [3:0]  cmd_cnt;
  logic        flag_act;
  logic [11:0] row;
  logic [8:0]  col;
  logic        in_wr;
  logic        pre_ok;
  logic        act_ok;
  logic [3:0]  nxt_cmd;
  logic [11:0] nxt_addr;

  assign in_wr = (state == WRITE);

`ifdef SDRAM_WR_AUTO_PRE_EN
  localparam logic AP = 1'b1;
  assign pre_ok = 1'b0;
  assign act_ok = 1'b1;
`else
  localparam logic AP = 1'b0;
  // A refresh closes the open row, so re-activate after one.
  assign pre_ok = (col == '0);
  assign act_ok = flag_act || (col == '0);
`endif

  sdram_addr_gen u_addr (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .adv     (flag_wr_end),
    .row     (row),
    .col     (col)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cmd_cnt     <= '0;
      flag_wr_end <= 1'b0;
      flag_act    <= 1'b0;
      wr_req      <= 1'b0;
    end else begin
      cmd_cnt     <= in_wr ? cmd_cnt + 4'd1 : '0;
      flag_wr_end <= (cmd_cnt == CMD_END);
      if (flag_wr_end)
        flag_act <= ref_req;
      if (wr_en)
        wr_req <= 1'b0;
      else if (key_wr && !in_wr)
        wr_req <= 1'b1;
    end
  end

  always_comb begin
    nxt_cmd  = NOP;
    nxt_addr = row;
    unique case (1'b1)
      cmd_cnt == 4'd2: if (pre_ok) nxt_cmd = PRE;
      cmd_cnt == 4'd3: if (act_ok) nxt_cmd = ACT;
      cmd_cnt == 4'd4: begin
        nxt_cmd  = WR;
        nxt_addr = col_word(col, AP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bus.sdram_cmd   <= NOP;
      bus.sdram_addr  <= '0;
      bus.sdram_bank  <= '0;
      bus.sdram_dq    <= '0;
      bus.sdram_dq_oe <= 1'b0;
      fifo_rd_en      <= 1'b0;
    end else begin
      bus.sdram_cmd   <= nxt_cmd;
      bus.sdram_addr  <= nxt_addr;
      bus.sdram_bank  <= '0;
      bus.sdram_dq    <= wr_data;
      bus.sdram_dq_oe <= (cmd_cnt >= 4'd4) && (cmd_cnt <= 4'd7);
      fifo_rd_en      <= (cmd_cnt >= 4'd2) && (cmd_cnt <= 4'd5);
    end
  end

endmodule

// File: tb/tb_sdram_wr.sv
// Bench for sdram_wr: handshake vector table, directed and random bursts
// against a linear-address reference model.
module tb_sdram_wr;
  import sdram_pkg::*;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        wr_en;
  logic [4:0]  state;
  logic        ref_req;
  logic        key_wr;
  logic [15:0] wr_data = '0;
  logic        wr_req;
  logic        flag_wr_end;
  logic        fifo_rd_en;

  sdram_wr_if bus ();

  sdram_wr dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .wr_en       (wr_en),
    .state       (state),
    .ref_req     (ref_req),
    .key_wr      (key_wr),
    .wr_data     (wr_data),
    .bus         (bus),
    .wr_req      (wr_req),
    .flag_wr_end (flag_wr_end),
    .fifo_rd_en  (fifo_rd_en)
  );

  always #5 sclk = ~sclk;

  logic [15:0] fifo_q[$];
  always @(posedge sclk)
    if (fifo_rd_en)
      wr_data <= (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'h0;

  int errors = 0;
  int checks = 0;
  bit m_req = 1'b0;
  int unsigned lin = 0;
  bit fact = 1'b0;
  localparam int unsigned TOTAL = 4096 * 512;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    bit nr;
    if (!s_rst_n) nr = 1'b0;
    else if (wr_en) nr = 1'b0;
    else if (key_wr && state != WRITE) nr = 1'b1;
    else nr = m_req;
    @(posedge sclk);
    #1;
    m_req = nr;
    chk("wr_req", {31'd0, wr_req}, {31'd0, m_req});
  endtask

  function automatic logic [3:0] exp_cmd(int c, int unsigned col, bit fa);
    if (c == 4) return WR;
`ifdef SDRAM_WR_AUTO_PRE_EN
    if (c == 3) return ACT;
`else
    if (c == 2 && col == 0) return PRE;
    if (c == 3 && (fa || col == 0)) return ACT;
`endif
    return NOP;
  endfunction

  // a = cycles spent in WRITE (13 = complete burst, fewer = abort)
  task automatic burst(input int a, input bit rr, input bit fixed);
    logic [15:0] b[4];
    int n, c, pops, flags;
    int unsigned col, row;
    logic [11:0] wa;
    fifo_q.delete();
    for (int i = 0; i < 4; i++) begin
      b[i] = fixed ? 16'hA001 + 16'(i) : 16'($urandom);
      fifo_q.push_back(b[i]);
    end
    ref_req = rr;
    state = WRITE;
    pops = 0;
    flags = 0;
    n = (a >= 13) ? 15 : a + 2;
    for (int j = 1; j <= n; j++) begin
      key_wr = 1'($urandom_range(0, 1));
      wr_en = ($urandom_range(0, 3) == 0);
      step();
      c = (j - 1 <= a) ? j - 1 : 0;
      col = lin % 512;
      row = lin / 512;
`ifdef SDRAM_WR_AUTO_PRE_EN
      wa = 12'h400 | 12'(col);
`else
      wa = 12'(col);
`endif
      chk("cmd", {28'd0, bus.sdram_cmd}, {28'd0, exp_cmd(c, col, fact)});
      chk("addr", {20'd0, bus.sdram_addr}, (c == 4) ? {20'd0, wa} : row);
      chk("bank", {30'd0, bus.sdram_bank}, 32'd0);
      chk("fifo_rd_en", {31'd0, fifo_rd_en}, (c >= 2 && c <= 5) ? 1 : 0);
      chk("dq_oe", {31'd0, bus.sdram_dq_oe}, (c >= 4 && c <= 7) ? 1 : 0);
      chk("flag_wr_end", {31'd0, flag_wr_end}, (c == 12) ? 1 : 0);
      if (c >= 4 && c <= 7)
        chk("dq", {16'd0, bus.sdram_dq}, {16'd0, b[c-4]});
      pops += int'(fifo_rd_en);
      flags += int'(flag_wr_end);
      if (a >= 13 && j == 14) begin
        lin = (lin + 4) % TOTAL;
        fact = rr;
      end
      if (j == a) state = AREF;
    end
    if (a >= 13) begin
      chk("pop_count", pops, 4);
      chk("end_count", flags, 1);
    end else begin
      chk("abort_end_count", flags, 0);
    end
  endtask

  typedef struct {
    logic       k;
    logic       e;
    logic [4:0] st;
    logic       exp;
  } req_vec_t;

  req_vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, AREF,  1'b1};
    tbl[1] = '{1'b0, 1'b0, AREF,  1'b1};
    tbl[2] = '{1'b0, 1'b1, AREF,  1'b0};
    tbl[3] = '{1'b1, 1'b1, AREF,  1'b0};
    tbl[4] = '{1'b1, 1'b0, WRITE, 1'b0};
    tbl[5] = '{1'b1, 1'b0, READ,  1'b1};
    tbl[6] = '{1'b1, 1'b0, WRITE, 1'b1};
    tbl[7] = '{1'b1, 1'b1, AREF,  1'b0};

    s_rst_n = 1'b0;
    wr_en = 1'b0;
    key_wr = 1'b0;
    ref_req = 1'b0;
    state = AREF;
    step();
    step();
    chk("rst_cmd", {28'd0, bus.sdram_cmd}, {28'd0, NOP});
    chk("rst_addr", {20'd0, bus.sdram_addr}, 32'd0);
    chk("rst_dq", {16'd0, bus.sdram_dq}, 32'd0);
    chk("rst_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    chk("rst_end", {31'd0, flag_wr_end}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    s_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      key_wr = tbl[i].k;
      wr_en = tbl[i].e;
      state = tbl[i].st;
      step();
      chk("req_table", {31'd0, wr_req}, {31'd0, tbl[i].exp});
    end
    key_wr = 1'b0;
    wr_en = 1'b0;
    state = AREF;
    step();

    burst(13, 1'b0, 1'b1);
    burst(13, 1'b0, 1'b0);
    burst(13, 1'b1, 1'b0);
    burst(5, 1'b0, 1'b0);
    burst(13, 1'b0, 1'b0);

    force dut.u_addr.col = 9'd508;
    force dut.u_addr.row = 12'd4095;
    #1;
    release dut.u_addr.col;
    release dut.u_addr.row;
    lin = 4095 * 512 + 508;
    burst(13, 1'b0, 1'b0);
    chk("wrap_lin", lin, 0);
    burst(13, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++)
      burst(($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 13,
            1'($urandom_range(0, 1)), 1'b0);

    key_wr = 1'b0;
    wr_en = 1'b0;
    state = WRITE;
    for (int i = 0; i < 6; i++) step();
    s_rst_n = 1'b0;
    #1;
    m_req = 1'b0;
    chk("arst_cmd", {28'd0, bus.sdram_cmd}, {28'd0, NOP});
    chk("arst_addr", {20'd0, bus.sdram_addr}, 32'd0);
    chk("arst_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    chk("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("arst_req", {31'd0, wr_req}, 32'd0);
    state = AREF;
    step();
    s_rst_n = 1'b1;
    lin = 0;
    fact = 1'b0;
    burst(13, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_wr.md
Name: sdram_wr

Overview:
Write-path engine of the SDRAM controller; it mirrors the existing read engine.
- While the top arbiter holds state = WRITE, it issues PRE/ACT/WR command sequences.
- Each sequence writes a 4-beat burst of 16-bit words, popped from an upstream write FIFO.
- Addresses advance sequentially through all 4096 rows x 512 columns and wrap to 0.
- It raises wr_req to the arbiter and pulses flag_wr_end at the end of each burst.

Parameters:
- NOP, 4'b0111: SDRAM command {cs_n, ras_n, cas_n, we_n}.
- PRE, 4'b0010: precharge command.
- ACT, 4'b0011: activate command.
- WR, 4'b0100: write command.
- CMD_END, 4'd12: cmd_cnt value that ends a burst slot.
- COL_END, 9'd508: first column of the last burst in a row.
- ROW_END, 12'd4095: last row.
- WRITE, 5'b10000: arbiter state code for write.
- AREF, 5'b00000: arbiter state code for auto-refresh.

Ports:
- sclk, in, 1: system clock.
- s_rst_n, in, 1: reset, asynchronous, active-low.
- wr_en, in, 1: arbiter grant; clears wr_req.
- state, in, 5: arbiter state.
- ref_req, in, 1: auto-refresh request pending.
- key_wr, in, 1: external write request.
- wr_data, in, 16: write-FIFO read data; valid 1 cycle after fifo_rd_en.
- sdram_cmd, out, 4: command bus.
- sdram_addr, out, 12: address bus.
- sdram_bank, out, 2: bank select; tied to 0.
- sdram_dq, out, 16: write data to the DQ tristate at top level.
- sdram_dq_oe, out, 1: DQ output enable.
- wr_req, out, 1: write request to the arbiter.
- flag_wr_end, out, 1: end-of-burst pulse.
- fifo_rd_en, out, 1: write-FIFO pop.

Behaviour:
- Reset values: sdram_cmd = NOP; sdram_addr = 0; sdram_bank = 0; sdram_dq = 0; sdram_dq_oe = 0; wr_req = 0; flag_wr_end = 0; fifo_rd_en = 0. Internal row_addr, col_addr, cmd_cnt and flag_act are 0. All outputs are registered.
- cmd_cnt: increments by 1 each cycle while state == WRITE; otherwise it is 0 the next cycle.
- flag_wr_end: set to 1 for exactly one cycle, on the cycle after cmd_cnt == CMD_END.
- wr_req:
  - Cleared when wr_en = 1. wr_en has priority over key_wr.
  - Otherwise set when key_wr = 1 and state != WRITE.
  - Otherwise held.
- flag_act: updated only when flag_wr_end = 1. It becomes ref_req, so ACT is forced on the next burst after a refresh closed the row.
- col_addr: on flag_wr_end, becomes 0 if it equals COL_END, else adds 4.
- row_addr: on flag_wr_end with col_addr == COL_END, increments; ROW_END wraps to 0.
- Command schedule (register output follows the cmd_cnt value of the previous cycle):
  - cnt 2: PRE if col_addr == 0, else NOP.
  - cnt 3: ACT if flag_act or col_addr == 0, else NOP.
  - cnt 4: WR.
  - all other counts: NOP.
- sdram_addr: {3'd0, col_addr} when cnt == 4 (A10 = 0, no auto-precharge); otherwise row_addr.
- Data path:
  - fifo_rd_en <= (cmd_cnt in 2..5), so it is high during cnt 3..6 (4 pops).
  - sdram_dq <= wr_data.
  - sdram_dq_oe <= (cmd_cnt in 4..7), so beat 0 coincides with the WR command on the bus and beats 1..3 follow; oe is high for exactly 4 cycles.
- Abort: if state leaves WRITE mid-burst, cmd_cnt goes to 0. From the next cycle, cmd = NOP, fifo_rd_en = 0 and dq_oe = 0. Addresses do not advance (no flag_wr_end).
- Reset mid-operation returns everything to its reset values immediately (asynchronous reset).

Optional Feature:
SDRAM_WR_AUTO_PRE_EN
- Defined:
  - WR is issued with sdram_addr[10] = 1 (auto-precharge).
  - The PRE at cnt 2 is never issued.
  - ACT is issued at cnt 3 for every burst.
- Undefined: behaviour is exactly as above.

Decomposition:
- Package sdram_pkg holds:
  - command codes NOP/PRE/ACT/RD/WR;
  - arbiter state codes AREF/READ/WRITE;
  - COL_END, ROW_END, CMD_END.
- One sub-module, sdram_addr_gen: row/col counters with wrap, advanced by an end-of-burst pulse. It is reusable by the read path.

Test Plan:
1. Reset, then key_wr pulse with state = 0 -> wr_req = 1 the next cycle; wr_en = 1 -> wr_req = 0 the next cycle; key_wr and wr_en asserted together -> wr_req stays 0.
2. state = WRITE for 13 cycles from reset -> sdram_cmd PRE, ACT, WR appear in consecutive cycles; WR addr = 0x000; 4 fifo_rd_en cycles; wr_data 0xA001..0xA004 appear on sdram_dq while dq_oe = 1, beat 0 aligned with WR; single flag_wr_end pulse; col_addr = 4.
3. Second burst (col = 4, ref_req = 0) -> no PRE, no ACT; WR addr = 0x004.
4. Preload col = 508, row = 4095 -> after flag_wr_end, col = 0, row = 0; the next burst issues PRE + ACT with row 0.
5. ref_req = 1 at flag_wr_end, then a burst at col = 8 -> ACT issued, no PRE. State drops out of WRITE at cnt 5 -> cmd = NOP, dq_oe = 0, no flag_wr_end, col unchanged.
6. Build with SDRAM_WR_AUTO_PRE_EN -> every burst is ACT then WR with addr[10] = 1; PRE is never seen.
